// File: rtl/regfile_param.sv
// Parametrised register file: N_RD registered read ports, one write port, entry 0 hardwired to zero,
// and a sequencer that walks and clears the file. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [N_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [N_RD-1:0]          rd_valid_q, rd_valid_d;
  logic                     clr_busy_q, clr_busy_d;
  logic                     clr_done_q, clr_done_d;
  logic                     wr_acc;
  logic [ADDR_W-1:0]        rd_a;

  always_comb begin
    wr_acc  = wr_en && (wr_addr != '0) && (state_q != S_CLEAR);
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (clr_req) begin
                 state_d = S_CLEAR;
                 idx_d   = ADDR_W'(1);
               end
      S_CLEAR: if (idx_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
               else                             idx_d   = idx_q + 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered so they line up with the state they describe.
    clr_busy_d = (state_d == S_CLEAR);
    clr_done_d = (state_d == S_DONE);

    mem_d = mem_q;
    if (wr_acc) mem_d[wr_addr] = wr_data;
    if (state_q == S_CLEAR) mem_d[idx_q] = '0;
    mem_d[0] = '0;

    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    rd_a       = '0;
    for (int p = 0; p < N_RD; p++) begin
      rd_a = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (rd_a == wr_addr)) rd_data_d[p*DATA_W +: DATA_W] = wr_data;
        else                             rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_a];
`else
        rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_a];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file with DEPTH entries of DATA_W bits, N_RD independent registered read ports, one write port, and a hardware sequencer that clears the whole file. Entry 0 is hardwired to zero. It sits between instruction decode (addresses) and the datapath (operands and writeback) and replaces the fixed two-entry, 8-bit register store.

## Interface
- DATA_W, 8, entry width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W (minimum ADDR_W = 1)
- N_RD, 2, number of read ports (minimum 1)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high; clock clk
- rd_en  in  N_RD  per-port read enable
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed registered read data; port p uses bits [p*DATA_W +: DATA_W]
- rd_valid  out  N_RD  per-port flag, high the cycle after an accepted read
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  request to clear the whole file; a single-cycle pulse is sufficient
- clr_busy  out  1  high while the clear sequencer is walking the file
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- Storage: DEPTH x DATA_W. Entry 0 always reads as 0. A write to address 0 is silently dropped.
- Write: when wr_en=1, wr_addr!=0 and the sequencer is not in CLEAR, mem[wr_addr] is loaded with wr_data on the clock edge.
- Read, port p:
  - rd_en[p]=1 → rd_data[p] is loaded with mem[rd_addr[p]] and rd_valid[p] is set to 1.
  - rd_en[p]=0 → rd_data[p] holds its value and rd_valid[p] is set to 0.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.
- Clear sequencer states and transitions:
  - IDLE: on clr_req=1, load idx=1 and go to CLEAR.
  - CLEAR: each cycle set mem[idx]=0. If idx==DEPTH-1, go to DONE; otherwise idx+1.
  - DONE: assert clr_done for one cycle, then go to IDLE.
- Sequencer outputs: clr_busy=1 only in CLEAR. clr_req is ignored in CLEAR and DONE; it is not queued.
- Writes during CLEAR are dropped with no error indication. Callers must hold writes while clr_busy=1.
- Reads during CLEAR are legal. They return the current contents: zero for entries already cleared, old data for the rest.
- clr_req and wr_en in the same IDLE cycle: the write completes, and CLEAR starts on the next cycle and erases it.

## Timing
- Reset values:
  - all mem entries 0
  - rd_data 0
  - rd_valid 0
  - clr_busy 0
  - clr_done 0
  - state IDLE, idx 0
- rst asserted mid-clear aborts the sequence. Everything returns to the reset values and no clr_done is produced.
- Read latency is 1 cycle: an address presented in cycle N gives data and rd_valid in cycle N+1.
- Write-to-read through storage: a write in cycle N is visible to a read issued in cycle N+1.
- Clear timing:
  - clr_req sampled in cycle N → clr_busy is high from N+1 through N+DEPTH-1 (DEPTH-1 cycles).
  - clr_done pulses in cycle N+DEPTH.
  - the file is writable again from N+DEPTH.
- Address values are always in range, because DEPTH = 2**ADDR_W. No bounds checking is needed.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Condition: a read on any port in the same cycle as an accepted write, with rd_addr[p]==wr_addr!=0.
  - Result: the read returns wr_data, which is the new value.
- REGFILE_BYPASS_EN undefined: the same read returns the old value of mem[wr_addr].
- No bypass occurs for address 0, or for writes dropped during CLEAR, in either build.

## Test plan
- Reset, then read all addresses on both ports → rd_data=0 and rd_valid=1 one cycle after each read.
- Write 0xA5 to addr 2, then read addr 2 on port 0 and addr 0 on port 1 the next cycle → port 0=0xA5, port 1=0x00. Write 0xFF to addr 0 → a later read of addr 0 returns 0x00.
- Write 0x3C to addr 1 and read addr 1 in the same cycle → 0x3C with REGFILE_BYPASS_EN, previous value without it.
- Fill addrs 1..3 with 0x11, 0x22, 0x33, then pulse clr_req:
  - clr_busy is high for exactly 3 cycles and clr_done pulses once.
  - all entries read 0 afterwards.
  - a write of 0x77 to addr 3 during clr_busy is dropped.
- Assert rst during the second CLEAR cycle → all outputs are 0 immediately, state is IDLE, and no clr_done occurs.
- Hold rd_en[1]=0 after a read returns 0x22 → rd_data[1] holds 0x22 and rd_valid[1]=0.
